// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the default operand width.
package serial_subtractor_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor.
// The optional signed-overflow flag is present only when SERIAL_SUB_OVF_EN is defined.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_subtractor_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB_OVF_EN
    logic             overflow;

    modport master (
        output start, a, b,
        input  diff, borrow_out, busy, done, overflow
    );

    modport slave (
        input  start, a, b,
        output diff, borrow_out, busy, done, overflow
    );
`else
    modport master (
        output start, a, b,
        input  diff, borrow_out, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow_out, busy, done
    );
`endif
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout is the borrow out.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (A - B), one bit per clock, LSB first.
// A single full_subtractor cell is time-shared across all bit positions; the
// borrow is carried between bits in a flop. Operands are captured when start
// is seen in IDLE; the result is held until the next operation completes.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a signed overflow flag.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_subtractor_if.slave   bus
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Registered state
    state_t           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_sh_r;
    logic             br_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;
    logic             busy_r;
    logic             done_r;

    // Next-state values
    state_t           state_s;
    logic [WIDTH-1:0] a_sh_s;
    logic [WIDTH-1:0] b_sh_s;
    logic [WIDTH-1:0] res_sh_s;
    logic             br_s;
    logic [CNT_W-1:0] cnt_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_out_s;
    logic             busy_s;
    logic             done_s;

    // Per-bit cell outputs
    logic             d_s;
    logic             bo_s;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_r;
    logic             b_msb_r;
    logic             overflow_r;
    logic             a_msb_s;
    logic             b_msb_s;
    logic             overflow_s;
`endif

    full_subtractor u_cell (
        .x    (a_sh_r[0]),
        .y    (b_sh_r[0]),
        .bin  (br_r),
        .d    (d_s),
        .bout (bo_s)
    );

    // Next-state and datapath decode: capture in IDLE, shift one bit per RUN cycle
    always_comb begin
        state_s      = state_r;
        a_sh_s       = a_sh_r;
        b_sh_s       = b_sh_r;
        res_sh_s     = res_sh_r;
        br_s         = br_r;
        cnt_s        = cnt_r;
        diff_s       = diff_r;
        borrow_out_s = borrow_out_r;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_s      = a_msb_r;
        b_msb_s      = b_msb_r;
        overflow_s   = overflow_r;
`endif

        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    a_sh_s   = bus.a;
                    b_sh_s   = bus.b;
                    res_sh_s = '0;
                    br_s     = 1'b0;
                    cnt_s    = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_s  = bus.a[WIDTH-1];
                    b_msb_s  = bus.b[WIDTH-1];
`endif
                    state_s  = RUN;
                end else begin
                    state_s  = IDLE;
                end
            end
            RUN: begin
                res_sh_s = {d_s, res_sh_r[WIDTH-1:1]};
                a_sh_s   = {1'b0, a_sh_r[WIDTH-1:1]};
                b_sh_s   = {1'b0, b_sh_r[WIDTH-1:1]};
                br_s     = bo_s;
                if (cnt_r == LAST_CNT) begin
                    // Last bit: publish the result; counter stays at its final value
                    diff_s       = {d_s, res_sh_r[WIDTH-1:1]};
                    borrow_out_s = bo_s;
`ifdef SERIAL_SUB_OVF_EN
                    // d_s is the MSB of the result on this cycle
                    overflow_s   = (a_msb_r ^ b_msb_r) & (a_msb_r ^ d_s);
`endif
                    state_s      = DONE;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = RUN;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE);
        done_s = (state_s == DONE);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh_r       <= '0;
            b_sh_r       <= '0;
            res_sh_r     <= '0;
            br_r         <= 1'b0;
            cnt_r        <= '0;
            diff_r       <= '0;
            borrow_out_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r      <= 1'b0;
            b_msb_r      <= 1'b0;
            overflow_r   <= 1'b0;
`endif
        end else begin
            a_sh_r       <= a_sh_s;
            b_sh_r       <= b_sh_s;
            res_sh_r     <= res_sh_s;
            br_r         <= br_s;
            cnt_r        <= cnt_s;
            diff_r       <= diff_s;
            borrow_out_r <= borrow_out_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_r      <= a_msb_s;
            b_msb_r      <= b_msb_s;
            overflow_r   <= overflow_s;
`endif
        end
    end

    assign bus.diff       = diff_r;
    assign bus.borrow_out = borrow_out_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.overflow   = overflow_r;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): spec vector table,
// randomized operations against an arithmetic reference, and hand-written
// sequences for re-pulsed start, held start and mid-operation reset.
module tb_serial_subtractor;

    localparam int W = 8;

    logic clk;
    logic rst;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt;
    int total_cnt;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_bo;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one operation from IDLE and check latency, busy span, result and pulse width.
    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input string tag);
        int lat;
        int busy_n;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.busy === 1'b1) busy_n++;
        check({tag, " latency"}, lat, W + 1);
        check({tag, " busy cycles"}, busy_n, W + 1);
        check({tag, " diff"}, bus.diff, ed);
        check({tag, " borrow_out"}, bus.borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
        check({tag, " overflow"}, bus.overflow, eo);
`else
        if (eo === 1'bx) $display("note: unexpected x in overflow expectation");
`endif
        @(posedge clk); #1;
        check({tag, " done low after pulse"}, bus.done, 1'b0);
        check({tag, " busy low after done"}, bus.busy, 1'b0);
        check({tag, " diff held"}, bus.diff, ed);
    endtask

    // Wait (bounded) until the DUT is idle.
    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " idle reached"}, bus.busy, 1'b0);
    endtask

    initial begin
        vec_t vecs [8];
        int   done_n;
        int   done_at [$];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rd;
        logic       rbo;
        logic       rov;
        int         sd;

        pass_cnt  = 0;
        total_cnt = 0;

        vecs[0] = '{8'd100, 8'd37,  8'd63,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0, 1'b0};
        vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1, 1'b0};
        vecs[5] = '{8'd200, 8'd50,  8'd150, 1'b0, 1'b0};
        vecs[6] = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[7] = '{8'h05,  8'h03,  8'd2,   1'b0, 1'b0};

        bus.start = 1'b0;
        bus.a     = 8'd0;
        bus.b     = 8'd0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset diff", bus.diff, 8'd0);
        check("reset borrow_out", bus.borrow_out, 1'b0);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        check("reset overflow", bus.overflow, 1'b0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        // Spec vectors
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_bo,
                  vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // Randomized operations against plain arithmetic
        for (int i = 0; i < 24; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rd  = 8'((int'(ra) - int'(rb)) & 255);
            rbo = (int'(ra) < int'(rb));
            sd  = int'($signed(ra)) - int'($signed(rb));
            rov = (sd > 127) || (sd < -128);
            do_op(ra, rb, rd, rbo, rov, $sformatf("rnd%0d", i));
        end

        // start re-pulsed during RUN with new operands: ignored
        bus.a     = 8'd100;
        bus.b     = 8'd37;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) done_n++;
            @(posedge clk); #1;
        end
        check("repulse done count", done_n, 1);
        check("repulse diff", bus.diff, 8'd63);
        check("repulse borrow_out", bus.borrow_out, 1'b0);

        // start held high for 30 cycles: back-to-back ops every WIDTH+2 cycles
        bus.a     = 8'd200;
        bus.b     = 8'd50;
        bus.start = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                done_at.push_back(i);
                check($sformatf("held diff@%0d", i), bus.diff, 8'd150);
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("held done count", done_at.size(), 3);
        for (int i = 1; i < done_at.size(); i++) begin
            check($sformatf("held spacing%0d", i), done_at[i] - done_at[i-1], W + 2);
        end
        wait_idle("held");

        // Asynchronous reset after 3 bits of an operation
        bus.a     = 8'd77;
        bus.b     = 8'd200;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst diff", bus.diff, 8'd0);
        check("midrst borrow_out", bus.borrow_out, 1'b0);
        check("midrst busy", bus.busy, 1'b0);
        check("midrst done", bus.done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_n++;
        end
        check("midrst no activity", done_n, 0);
        do_op(8'h05, 8'h03, 8'd2, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_serial_subtractor
